// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute
// and drives every datapath select, write enable and the 3-bit ALU control code.
module mips_multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t     state_r;
    state_t     next_s;
    logic       pcwrite_s;
    logic       branch_s;
    logic       iord_s;
    logic       memwrite_s;
    logic       irwrite_s;
    logic       regdst_s;
    logic       memtoreg_s;
    logic       regwrite_s;
    logic       alusrca_s;
    logic [1:0] alusrcb_s;
    logic [1:0] pcsrc_s;
    logic [2:0] alucontrol_s;
    logic       done_s;
    logic       illegal_s;

    // State register; reset aborts any instruction in flight and returns to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and control decode from the current state (plus opcode/funct where sampled).
    always_comb begin
        next_s       = S_FETCH;
        pcwrite_s    = 1'b0;
        branch_s     = 1'b0;
        iord_s       = 1'b0;
        memwrite_s   = 1'b0;
        irwrite_s    = 1'b0;
        regdst_s     = 1'b0;
        memtoreg_s   = 1'b0;
        regwrite_s   = 1'b0;
        alusrca_s    = 1'b0;
        alusrcb_s    = 2'b00;
        pcsrc_s      = 2'b00;
        alucontrol_s = 3'b010;
        done_s       = 1'b0;
        illegal_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                alusrcb_s = 2'b01;
                irwrite_s = 1'b1;
                pcwrite_s = 1'b1;
                next_s    = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here so BRANCH only has to compare.
                alusrcb_s = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: next_s = S_MEMADR;
                    OP_RTYPE:     next_s = S_EXECUTE;
                    OP_BEQ:       next_s = S_BRANCH;
                    OP_ADDI:      next_s = S_ADDIEX;
                    OP_J:         next_s = S_JUMP;
                    default: begin
                        next_s    = S_FETCH;
                        illegal_s = 1'b1;
                        done_s    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                if (opcode == OP_LW) begin
                    next_s = S_MEMRD;
                end else begin
                    next_s = S_MEMWR;
                end
            end
            S_MEMRD: begin
                iord_s = 1'b1;
                next_s = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg_s = 1'b1;
                regwrite_s = 1'b1;
                done_s     = 1'b1;
            end
            S_MEMWR: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
                done_s     = 1'b1;
            end
            S_EXECUTE: begin
                alusrca_s = 1'b1;
                next_s    = S_ALUWB;
                // Unknown funct flags illegal but still completes as an add.
                case (funct)
                    6'b100000: alucontrol_s = 3'b010;
                    6'b100010: alucontrol_s = 3'b110;
                    6'b100100: alucontrol_s = 3'b000;
                    6'b100101: alucontrol_s = 3'b001;
                    6'b101010: alucontrol_s = 3'b111;
                    default: begin
                        alucontrol_s = 3'b010;
                        illegal_s    = 1'b1;
                    end
                endcase
            end
            S_ALUWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
                done_s     = 1'b1;
            end
            S_BRANCH: begin
                alusrca_s    = 1'b1;
                alucontrol_s = 3'b110;
                pcsrc_s      = 2'b01;
                branch_s     = 1'b1;
                done_s       = 1'b1;
            end
            S_ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                next_s    = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
                done_s     = 1'b1;
            end
            S_JUMP: begin
                pcsrc_s   = 2'b10;
                pcwrite_s = 1'b1;
                done_s    = 1'b1;
            end
            default: begin
                illegal_s = 1'b1;
                next_s    = S_FETCH;
            end
        endcase
    end

    // Enables and pulses are held off while reset is asserted; selects keep FETCH values.
    assign pcen       = rst_n & (pcwrite_s | (branch_s & zero));
    assign irwrite    = rst_n & irwrite_s;
    assign regwrite   = rst_n & regwrite_s;
    assign memwrite   = rst_n & memwrite_s;
    assign instr_done = rst_n & done_s;
    assign illegal    = rst_n & illegal_s;
    assign iord       = iord_s;
    assign regdst     = regdst_s;
    assign memtoreg   = memtoreg_s;
    assign alusrca    = alusrca_s;
    assign alusrcb    = alusrcb_s;
    assign pcsrc      = pcsrc_s;
    assign alucontrol = alucontrol_s;
    assign state      = state_r;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed scoreboard bench for mips_multicycle_control: per-cycle expected control
// vectors are queued with each instruction and compared at the falling clock edge.
module tb_mips_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       instr_done, illegal;
    logic [3:0] state;

    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca, alusrcb, pcsrc, alucontrol, done, illegal}
    logic [20:0] obs;
    assign obs = {state, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, pcsrc, alucontrol, instr_done, illegal};

    typedef struct {
        string       tag;
        logic [20:0] vec;
    } exp_t;

    exp_t sb[$];
    int   n_compared = 0;
    int   n_failed   = 0;

    function automatic logic [20:0] ev(input logic [3:0] st, input logic [7:0] en,
                                       input logic [1:0] asb, input logic [1:0] ps,
                                       input logic [2:0] aluc, input logic dn, input logic il);
        return {st, en, asb, ps, aluc, dn, il};
    endfunction

    logic [20:0] v_reset, v_fetch, v_decode, v_dec_ill, v_memadr, v_memrd, v_memwb, v_memwr;
    logic [20:0] v_aluwb, v_addiex, v_addiwb, v_jump;

    task automatic push(input string tag, input logic [20:0] v);
        exp_t e;
        e.tag = tag;
        e.vec = v;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        n_compared++;
        if (sb.size() == 0) begin
            n_failed++;
            $error("FAIL sb_empty: observed %h expected <queued entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.vec) else begin
                n_failed++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.vec);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op;
        funct  = fn;
        zero   = z;
        while (sb.size() != 0) step();
    endtask

    initial begin
        v_reset   = ev(4'd0,  8'b0000_0000, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0);
        v_fetch   = ev(4'd0,  8'b1001_0000, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0);
        v_decode  = ev(4'd1,  8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b0, 1'b0);
        v_dec_ill = ev(4'd1,  8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b1, 1'b1);
        v_memadr  = ev(4'd2,  8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0);
        v_memrd   = ev(4'd3,  8'b0100_0000, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0);
        v_memwb   = ev(4'd4,  8'b0000_0110, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0);
        v_memwr   = ev(4'd5,  8'b0110_0000, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0);
        v_aluwb   = ev(4'd7,  8'b0000_1010, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0);
        v_addiex  = ev(4'd9,  8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0);
        v_addiwb  = ev(4'd10, 8'b0000_0010, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0);
        v_jump    = ev(4'd11, 8'b1000_0000, 2'b00, 2'b10, 3'b010, 1'b1, 1'b0);

        opcode = 6'b000000;
        funct  = 6'b100000;
        zero   = 1'b0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset held for three cycles: enables low, selects at FETCH values.
        push("reset0", v_reset); push("reset1", v_reset); push("reset2", v_reset);
        run(6'b000000, 6'b100000, 1'b0);
        rst_n = 1'b1;

        push("lw_fetch", v_fetch); push("lw_decode", v_decode); push("lw_memadr", v_memadr);
        push("lw_memrd", v_memrd); push("lw_memwb", v_memwb);
        run(6'b100011, 6'b000000, 1'b0);

        push("sw_fetch", v_fetch); push("sw_decode", v_decode); push("sw_memadr", v_memadr);
        push("sw_memwr", v_memwr);
        run(6'b101011, 6'b000000, 1'b0);

        push("slt_fetch", v_fetch); push("slt_decode", v_decode);
        push("slt_exec", ev(4'd6, 8'b0000_0001, 2'b00, 2'b00, 3'b111, 1'b0, 1'b0));
        push("slt_aluwb", v_aluwb);
        run(6'b000000, 6'b101010, 1'b0);

        push("sub_fetch", v_fetch); push("sub_decode", v_decode);
        push("sub_exec", ev(4'd6, 8'b0000_0001, 2'b00, 2'b00, 3'b110, 1'b0, 1'b0));
        push("sub_aluwb", v_aluwb);
        run(6'b000000, 6'b100010, 1'b0);

        push("beqt_fetch", v_fetch); push("beqt_decode", v_decode);
        push("beqt_branch", ev(4'd8, 8'b1000_0001, 2'b00, 2'b01, 3'b110, 1'b1, 1'b0));
        run(6'b000100, 6'b000000, 1'b1);

        push("beqn_fetch", v_fetch); push("beqn_decode", v_decode);
        push("beqn_branch", ev(4'd8, 8'b0000_0001, 2'b00, 2'b01, 3'b110, 1'b1, 1'b0));
        run(6'b000100, 6'b000000, 1'b0);

        push("ill_fetch", v_fetch); push("ill_decode", v_dec_ill);
        run(6'b111111, 6'b000000, 1'b0);

        push("badf_fetch", v_fetch); push("badf_decode", v_decode);
        push("badf_exec", ev(4'd6, 8'b0000_0001, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1));
        push("badf_aluwb", v_aluwb);
        run(6'b000000, 6'b000111, 1'b0);

        push("addi_fetch", v_fetch); push("addi_decode", v_decode);
        push("addi_ex", v_addiex); push("addi_wb", v_addiwb);
        run(6'b001000, 6'b000000, 1'b0);

        push("j_fetch", v_fetch); push("j_decode", v_decode); push("j_jump", v_jump);
        run(6'b000010, 6'b000000, 1'b0);

        // lw aborted by reset during MEMRD: state returns to FETCH without waiting for a clock.
        push("abort_fetch", v_fetch); push("abort_decode", v_decode); push("abort_memadr", v_memadr);
        run(6'b100011, 6'b000000, 1'b0);
        push("abort_memrd", v_memrd);
        @(negedge clk);
        check();
        #2 rst_n = 1'b0;
        #1;
        push("abort_async", v_reset);
        check();
        @(posedge clk);
        #1;
        push("abort_hold", v_reset);
        run(6'b100011, 6'b000000, 1'b0);
        rst_n = 1'b1;

        push("post_fetch", v_fetch); push("post_decode", v_decode); push("post_memadr", v_memadr);
        push("post_memrd", v_memrd); push("post_memwb", v_memwb);
        run(6'b100011, 6'b000000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
